// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Fixed latency of WIDTH+1 edges from the start edge to the end of the done pulse.
// Optional feature macro MDU_DIV_EN: when defined, the divider datapath is built
// and DIVU/DIV are executed. When undefined, divide ops finish immediately with
// err=1 and hi/lo untouched.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 err_q, err_d;

  // Magnitude of an operand; only negated when the op is signed (op[0]).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  logic [WIDTH-1:0]   ma, mb;
  assign ma = mag(a_q, op_q[0]);
  assign mb = mag(b_q, op_q[0]);

  // Multiply: acc = {partial sum, remaining multiplier bits}; add then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_n, mul_res;
  logic               mul_neg;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? ma : {WIDTH{1'b0}})};
  assign mul_n   = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_neg = op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign mul_res = mul_neg ? -mul_n : mul_n;

  logic [2*WIDTH-1:0] acc_next;

`ifdef MDU_DIV_EN
  // Divide: acc = {partial remainder, dividend bits / quotient bits}; shift left,
  // trial-subtract, keep the difference only when it does not underflow.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff, div_rem, q_fix, r_fix;
  logic [2*WIDTH-1:0] div_n;
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, mb};
  assign div_diff = div_sh[WIDTH-1:0] - mb;
  assign div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_n    = {div_rem, acc_q[WIDTH-2:0], div_ge};
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  // MIN / -1 falls out naturally: |q| = 2^(W-1) negates back to MIN.
  assign q_fix    = (op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_n[WIDTH-1:0]
                                                                : div_n[WIDTH-1:0];
  assign r_fix    = (op_q[0] & a_q[WIDTH-1]) ? -div_n[2*WIDTH-1:WIDTH]
                                             : div_n[2*WIDTH-1:WIDTH];
  assign acc_next = op_q[1] ? div_n : mul_n;
`else
  assign acc_next = mul_n;
`endif

  // Next-state and datapath update; every register holds unless its state says otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = srcA;
          b_d   = srcB;
          err_d = 1'b0;
`ifdef MDU_DIV_EN
          cnt_d   = CNT_INIT;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, mag(srcA, op[0])}
                          : {{WIDTH{1'b0}}, mag(srcB, op[0])};
          state_d = CALC;
`else
          if (op[1]) begin
            // No divider: report the op as unsupported right away.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            acc_d   = {{WIDTH{1'b0}}, mag(srcB, op[0])};
            state_d = CALC;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        acc_d = acc_next;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          if (op_q[1]) begin
`ifdef MDU_DIV_EN
            if (b_q == '0) begin
              lo_d  = '1;
              hi_d  = a_q;
              err_d = 1'b1;
            end else begin
              lo_d  = q_fix;
              hi_d  = r_fix;
              err_d = 1'b0;
            end
`else
            err_d = 1'b1;
`endif
          end else begin
            {hi_d, lo_d} = mul_res;
            err_d        = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
